iterative_neg_log: RTL

Sequential inverse of the pipelined exp(-x) unit: takes y in (0,1) as unsigned Q0.64 and returns x = -ln(y) as unsigned Q32.32, the same format the exponent pipeline consumes. Multiplicative-normalization algorithm:
- one leading-zero normalization step;
- 32 shift-add iterations, one per cycle, driven by a constant ROM.

It sits beside the exponent pipeline in the datapath: the recovered x can be fed back into the exponent unit, and the two blocks verify each other.

---
 rtl/exp_log_pkg.sv | 46 ++++
 rtl/lzc64.sv | 17 +
 rtl/iterative_neg_log.sv | 112 +++++++++++
 3 files changed

// File: rtl/exp_log_pkg.sv
// rtl/exp_log_pkg.sv - constants and types shared by the exp(-x) pipeline and iterative_neg_log
package exp_log_pkg;

    localparam int Q0_64_W     = 64;
    localparam int Q32_32_W    = 64;
    localparam int Q32_32_FRAC = 32;
    localparam int K_W         = 6;

    typedef logic [Q32_32_W-1:0] q32_32_t;
    typedef logic [63:0][Q32_32_W-1:0] lnk_table_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NORM,
        ST_ITER,
        ST_DONE
    } state_t;

    localparam q32_32_t LN2_Q32_32 = 64'h0000_0000_B172_17F8;

    // Exponent-direction range reduction constant: log2(e) in unsigned Q1.63.
    localparam logic [63:0] EXP_LOG2E_Q1_63 = 64'hB8AA_3B29_5C17_F0BC;

    // ln(1+2^-k) from its alternating series in Q0.64, rounded to Q32.32; unused slots are zero.
    function automatic lnk_table_t gen_lnk();
        lnk_table_t  tbl;
        logic [63:0] sum;
        logic [63:0] term;
        tbl = '0;
        for (int k = 1; k <= 32; k++) begin
            sum = '0;
            for (int n = 1; n < 64; n++) begin
                if (k * n < 64) begin
                    term = (64'd1 << (64 - k * n)) / 64'(n);
                    if (n % 2 == 1) sum = sum + term;
                    else            sum = sum - term;
                end
            end
            tbl[6'(k)] = (sum + 64'h0000_0000_8000_0000) >> Q32_32_FRAC;
        end
        return tbl;
    endfunction

    localparam lnk_table_t LNK = gen_lnk();

endpackage

// File: rtl/lzc64.sv
// rtl/lzc64.sv - combinational 64-bit leading-zero counter with all-zero flag
module lzc64 (
    input  logic [63:0] data_i,
    output logic [6:0]  cnt_o,
    output logic        zero_o
);

    always_comb begin
        cnt_o = 7'd64;
        for (int i = 0; i < 64; i++) begin
            if (data_i[i]) cnt_o = 7'(63 - i);
        end
    end

    assign zero_o = (data_i == '0);

endmodule

// File: rtl/iterative_neg_log.sv
// rtl/iterative_neg_log.sv - sequential -ln(y), Q0.64 in, Q32.32 out, by multiplicative normalization
module iterative_neg_log
    import exp_log_pkg::*;
#(
    parameter int ITERS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [Q0_64_W-1:0]  y_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [Q32_32_W-1:0] x_out,
    output logic                err,
    output logic                out_valid,
    input  logic                out_ready
);

    state_t        state_q, state_d;
    logic [K_W-1:0] k_q, k_d;
    logic [63:0]   y_q, y_d;
    q32_32_t       acc_q, acc_d;
    logic          err_q, err_d;
    logic          out_valid_q, out_valid_d;

    logic [6:0]    lz_cnt;
    logic          lz_zero;
    logic [64:0]   t;
    q32_32_t       norm_prod;

    lzc64 u_lzc (
        .data_i (y_q),
        .cnt_o  (lz_cnt),
        .zero_o (lz_zero)
    );

    // A carry out of t means y*(1+2^-k) would reach 1.0, so that factor is skipped.
    assign t         = {1'b0, y_q} + ({1'b0, y_q} >> k_q);
    assign norm_prod = LN2_Q32_32 * {57'd0, lz_cnt};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            y_q         <= '0;
            acc_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            y_q         <= y_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        y_d         = y_q;
        acc_d       = acc_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    y_d     = y_in;
                    acc_d   = '0;
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (lz_zero) begin
                    err_d   = 1'b1;
                    acc_d   = '1;
                    state_d = ST_DONE;
                end else begin
                    y_d     = y_q << lz_cnt;
                    acc_d   = norm_prod;
                    k_d     = K_W'(1);
                    state_d = ST_ITER;
                end
            end
            ST_ITER: begin
                if (!t[64]) begin
                    y_d   = t[63:0];
                    acc_d = acc_q + LNK[k_q];
                end
                k_d = k_q + K_W'(1);
                if (k_q == K_W'(ITERS)) state_d = ST_DONE;
            end
            ST_DONE: begin
                // out_valid is raised one cycle after entering DONE and dropped on handshake.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    err_d       = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign x_out     = acc_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;

endmodule
